// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the 1011 detector: WIDTH-bit words in over valid/ready, one bit per clock on xout.
// Latency: first bit appears one clock after the accept edge; back-to-back words stream with no idle bit.
// Backpressure: din_ready only in IDLE or on a word's last bit; din_valid at other times is ignored and the source holds din.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             xout,
    output logic             xout_valid,
    output logic             frame_done,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] shift_val;

    assign last_bit   = (state_q == SHIFT) && (bit_cnt == LAST);
    assign din_ready  = (state_q == IDLE) || last_bit;
    assign accept     = din_valid && din_ready;
    assign frame_done = xout_valid && (bit_cnt == LAST);
    assign busy       = (state_q == SHIFT);

    // The register holds the bits not yet on xout, pre-shifted so the next bit sits at the outgoing end.
    assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign load_val   = MSB_FIRST ? (din << 1) : (din >> 1);
    assign shift_val  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            xout       <= IDLE_BIT;
            xout_valid <= 1'b0;
            word_cnt   <= '0;
        end else begin
            if (accept) begin
                shreg      <= load_val;
                xout       <= first_bit;
                xout_valid <= 1'b1;
                bit_cnt    <= '0;
            end else if (state_q == SHIFT && !last_bit) begin
                shreg      <= shift_val;
                xout       <= next_bit;
                bit_cnt    <= bit_cnt + CW'(1);
            end else if (last_bit) begin
                xout       <= IDLE_BIT;
                xout_valid <= 1'b0;
                bit_cnt    <= '0;
            end
            if (last_bit) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share one input stream and are
// checked every cycle against an expected bit list built from the words sent.
module tb_seq_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;

    logic        rdy_m, xo_m, xv_m, fd_m, bz_m;
    logic [15:0] wc_m;
    logic        rdy_l, xo_l, xv_l, fd_l, bz_l;
    logic [15:0] wc_l;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] wc_exp;
    logic [7:0]  tx_q[$];

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .xout(xo_m), .xout_valid(xv_m), .frame_done(fd_m), .busy(bz_m), .word_cnt(wc_m)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .xout(xo_l), .xout_valid(xv_l), .frame_done(fd_l), .busy(bz_l), .word_cnt(wc_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " xout_m"}, 32'(xo_m), 32'd0);
        check({tag, " xout_l"}, 32'(xo_l), 32'd0);
        check({tag, " xout_valid"}, 32'(xv_m), 32'd0);
        check({tag, " frame_done"}, 32'(fd_m), 32'd0);
        check({tag, " busy"}, 32'(bz_m), 32'd0);
        check({tag, " din_ready"}, 32'(rdy_m), 32'd1);
        check({tag, " word_cnt_m"}, 32'(wc_m), 32'(wc_exp));
        check({tag, " word_cnt_l"}, 32'(wc_l), 32'(wc_exp));
    endtask

    // Sends every word in tx_q with din_valid held high (so words chain back-to-back),
    // comparing both serial streams cycle by cycle against the expected bit lists.
    task automatic run_stream();
        bit   bm[$];
        bit   bl[$];
        int   p;
        int   cyc;
        logic rdy;
        logic acc;
        logic eb_m;
        logic eb_l;
        foreach (tx_q[j]) begin
            for (int i = 0; i < 8; i++) begin
                bm.push_back(tx_q[j][7-i]);
                bl.push_back(tx_q[j][i]);
            end
        end
        p   = -1;
        cyc = 0;
        @(posedge clk);
        #1;
        din_valid = 1'b1;
        din       = tx_q.pop_front();
        do begin
            @(negedge clk);
            rdy  = (p < 0) || (p % 8 == 7);
            eb_m = 1'b0;
            eb_l = 1'b0;
            if (p >= 0) begin
                eb_m = bm[p];
                eb_l = bl[p];
            end
            check("din_ready_m", 32'(rdy_m), 32'(rdy));
            check("din_ready_l", 32'(rdy_l), 32'(rdy));
            check("xout_valid", 32'(xv_m), 32'(p >= 0));
            check("xout_m", 32'(xo_m), 32'(eb_m));
            check("xout_l", 32'(xo_l), 32'(eb_l));
            check("frame_done", 32'(fd_m), 32'((p >= 0) && (p % 8 == 7)));
            check("busy", 32'(bz_m), 32'(p >= 0));
            check("word_cnt", 32'(wc_m), 32'(wc_exp));
            acc = din_valid && rdy;
            @(posedge clk);
            #1;
            if (p >= 0 && p % 8 == 7) wc_exp++;
            if (acc) begin
                p = p + 1;
                if (tx_q.size() > 0) begin
                    din = tx_q.pop_front();
                end else begin
                    din_valid = 1'b0;
                    din       = 8'($urandom);
                end
            end else if (p >= 0 && p % 8 != 7) begin
                p = p + 1;
            end else begin
                p = -1;
            end
            if (!din_valid) din = 8'($urandom);
            cyc++;
        end while ((p >= 0 || din_valid) && cyc < 300);
        check("stream_timeout", 32'(cyc < 300), 32'd1);
        @(negedge clk);
        check_idle("after_stream");
    endtask

    initial begin
        rst       = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        wc_exp    = 16'd0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;

        tx_q = '{8'hB0};
        run_stream();

        tx_q = '{8'h0B, 8'hB0};
        run_stream();

        tx_q = '{8'h0D};
        run_stream();

        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            run_stream();
        end

        // Abort a word after three bits with an asynchronous reset between clock edges.
        @(posedge clk);
        #1;
        din_valid = 1'b1;
        din       = 8'hA5;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_abort busy", 32'(bz_m), 32'd1);
        rst = 1'b0;
        #1;
        wc_exp = 16'd0;
        check_idle("async_reset");
        @(negedge clk);
        rst = 1'b1;
        tx_q = '{8'h3C};
        run_stream();

        @(negedge clk);
        force dut_m.word_cnt = 16'hFFFF;
        force dut_l.word_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_m.word_cnt;
        release dut_l.word_cnt;
        wc_exp = 16'hFFFF;
        check("preset word_cnt", 32'(wc_m), 32'h0000FFFF);
        tx_q = '{8'h96};
        run_stream();
        check("wrapped word_cnt", 32'(wc_m), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial front end for the 1011 Moore sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on xout, which drives the detector's xin. Words can stream back-to-back with no idle bit between them, so multi-word patterns reach the detector contiguously. It also flags the last bit of each word and counts completed words.

Parameters:
WIDTH, 8, bits per word; legal range 2..32
MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first
IDLE_BIT, 0, value driven on xout while no word is being sent

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  serializer can accept a word this cycle
xout  output  1  serial bit to the detector's xin; registered
xout_valid  output  1  xout carries a data bit this cycle; registered
frame_done  output  1  high during the cycle in which xout carries the last bit of a word
busy  output  1  high when state is SHIFT
word_cnt  output  16  number of completed words; wraps from 0xFFFF to 0

Behaviour:
- Reset (rst=0, asynchronous, overrides everything):
  - state=IDLE, shift register=0, bit_cnt=0
  - xout=IDLE_BIT, xout_valid=0, frame_done=0, busy=0, word_cnt=0
- States: IDLE and SHIFT.
- Accept: a word is taken at a rising edge when din_valid=1 and din_ready=1.
- din_ready (combinational from registered state):
  - 1 in IDLE
  - 1 in SHIFT only when bit_cnt=WIDTH-1 (last bit on xout)
  - 0 otherwise
  - Words are never dropped: din_valid asserted while din_ready=0 is ignored, and the source holds din.
- IDLE plus accept:
  - next cycle: state=SHIFT, bit_cnt=0
  - xout=first bit (din[WIDTH-1] if MSB_FIRST=1, else din[0]), xout_valid=1
  - Latency from accept edge to first bit on xout is one clock.
- SHIFT with bit_cnt<WIDTH-1: the next edge presents the next bit in order and bit_cnt increments.
- SHIFT with bit_cnt=WIDTH-1 (frame_done=1):
  - word_cnt increments at the next edge.
  - With an accept at that edge: reload from din, bit_cnt=0, stay in SHIFT; the new word's first bit follows immediately with no gap.
  - Without an accept: state=IDLE, xout=IDLE_BIT, xout_valid=0.
- frame_done = xout_valid AND (bit_cnt = WIDTH-1). It is one cycle wide per word.
- busy = (state = SHIFT).
- din is sampled only at the accept edge; later changes to din do not affect the word in flight.
- A reset mid-word aborts the word: the remaining bits are discarded and word_cnt is not incremented.
- In IDLE with din_valid=0: outputs stay at their idle values indefinitely.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, din=0xB0 with one-cycle valid → one clock later xout=1,0,1,1,0,0,0,0 with xout_valid=1 for 8 cycles; frame_done on the 8th bit; then xout=0, xout_valid=0; word_cnt=1.
- Back-to-back: din=0x0B then 0xB0, din_valid held high → 16 contiguous valid bits 00001011 10110000 with no gap; din_ready high only on cycles 8 and 16; word_cnt=2.
- MSB_FIRST=0, din=0x0D → xout=1,0,1,1,0,0,0,0; the detector fed from xout asserts zout after bit 4.
- Hold din_valid=1 with a new value while SHIFT is mid-word → no accept until bit_cnt=7; the in-flight word is unchanged.
- Assert rst=0 mid-word after 3 bits → outputs go to reset values immediately (asynchronously), word_cnt=0; after release, a fresh word serializes correctly from bit 0.
- Send 0x10000 words, e.g. by forcing word_cnt to 0xFFFF → word_cnt wraps to 0 after the next completed word.
